wptr_full: RTL and testbench



---
 rtl/wptr_full.sv | 85 ++++++++
 tb/tb_wptr_full.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer, full/level/overflow generator for the async FIFO (write clock domain).
// Optional almost-full flag is built only when WPTR_FULL_AFULL_EN is defined.
module wptr_full #(
  parameter int ADDRSIZE     = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  if ((ADDRSIZE < 2) || (AFULL_THRESH < 1) || (AFULL_THRESH > (1 << ADDRSIZE))) begin : g_bad_params
    $error("wptr_full: illegal ADDRSIZE/AFULL_THRESH");
  end

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_r;
  logic              wpush_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] wlevelnext_s;
  logic              wfullnext_s;

  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wpush_s      = winc & ~wfull;
  assign wbinnext_s   = wbin_r + {{ADDRSIZE{1'b0}}, wpush_s};
  assign wgraynext_s  = bin2gray(wbinnext_s);
  assign rbin_s       = gray2bin(wq2_rptr);
  assign wlevelnext_s = wbinnext_s - rbin_s;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign wfullnext_s  = (wgraynext_s == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  // Pointer, full, level and sticky overflow registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_r    <= {(ADDRSIZE+1){1'b0}};
      wptr      <= {(ADDRSIZE+1){1'b0}};
      wfull     <= 1'b0;
      wlevel    <= {(ADDRSIZE+1){1'b0}};
      woverflow <= 1'b0;
    end else begin
      wbin_r    <= wbinnext_s;
      wptr      <= wgraynext_s;
      wfull     <= wfullnext_s;
      wlevel    <= wlevelnext_s;
      woverflow <= woverflow | (winc & wfull);
    end
  end

`ifdef WPTR_FULL_AFULL_EN
  localparam logic [ADDRSIZE:0] AFULL_THRESH_C = (ADDRSIZE+1)'(AFULL_THRESH);

  // Almost-full register, same edge as wfull.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull <= 1'b0;
    end else begin
      wafull <= (wlevelnext_s >= AFULL_THRESH_C);
    end
  end
`else
  assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Randomised self-checking bench for wptr_full against an occupancy-count model.
// Honours WPTR_FULL_AFULL_EN when checking wafull.
module tb_wptr_full;
  localparam int AS = 3;
  localparam int DEPTH = 1 << AS;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          wafull;
  logic [AS:0]   wlevel;
  logic          woverflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: unbounded counts of accepted writes and of reads seen by the write side.
  int m_wr  = 0;
  int m_rd  = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  wptr_full #(.ADDRSIZE(AS), .AFULL_THRESH(6)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .waddr     (waddr),
    .wptr      (wptr),
    .wfull     (wfull),
    .wafull    (wafull),
    .wlevel    (wlevel),
    .woverflow (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock: present inputs, apply the model at the edge, then compare.
  task automatic step(input bit w, input int rd_new, input bit rst);
    int lvl;
    int afull_exp;
    winc     = w;
    wrst     = rst;
    wq2_rptr = (AS+1)'(gray(rd_new % (2 * DEPTH)));
    @(posedge wclk);
    if (rst) begin
      m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      if (w && m_full) m_ovf = 1'b1;
      if (w && !m_full) m_wr++;
      m_rd   = rd_new;
      m_full = ((m_wr - m_rd) == DEPTH);
    end
    lvl = m_wr - m_rd;
`ifdef WPTR_FULL_AFULL_EN
    afull_exp = (lvl >= 6) ? 1 : 0;
`else
    afull_exp = 0;
`endif
    #1;
    check("waddr",     int'(waddr),     m_wr % DEPTH);
    check("wptr",      int'(wptr),      gray(m_wr % (2 * DEPTH)));
    check("wfull",     int'(wfull),     int'(m_full));
    check("wlevel",    int'(wlevel),    lvl);
    check("wafull",    int'(wafull),    afull_exp);
    check("woverflow", int'(woverflow), int'(m_ovf));
    winc = 1'b0;
  endtask

  int fill_tab[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

  initial begin
    int rd_new;
    bit w;
    winc = 1'b0; wrst = 1'b1; wq2_rptr = '0;

    // Reset with writes presented: dropped, no overflow.
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1);
    check("rst_wptr",  int'(wptr), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_ovf",   int'(woverflow), 0);

    // Fill 8 entries against an idle reader.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 0, 1'b0);
      check("fill_wptr", int'(wptr), fill_tab[k]);
    end
    check("fill_full",  int'(wfull), 1);
    check("fill_level", int'(wlevel), 8);

    // Write while full: rejected, overflow sticks.
    step(1'b1, 0, 1'b0);
    check("ovf_wptr",  int'(wptr), 12);
    check("ovf_level", int'(wlevel), 8);
    check("ovf_set",   int'(woverflow), 1);
    step(1'b0, 0, 1'b0);
    check("ovf_sticky", int'(woverflow), 1);

    // Read release then refill.
    step(1'b0, 1, 1'b0);
    check("rel_full",  int'(wfull), 0);
    check("rel_level", int'(wlevel), 7);
    step(1'b1, 1, 1'b0);
    check("refill_full", int'(wfull), 1);
    check("refill_wptr", int'(wptr), 13);

    // Wrap: reader tracks two behind through a full pointer lap.
    step(1'b0, 0, 1'b1);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, m_wr - 1, 1'b0);
      check("wrap_level", int'(wlevel), 2);
      check("wrap_full",  int'(wfull), 0);
    end

    // Random traffic with occasional mid-run reset.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 0, 1'b1);
      end else begin
        w = ($urandom_range(0, 99) < 55);
        rd_new = m_rd;
        if ((m_rd < m_wr) && ($urandom_range(0, 99) < 45)) rd_new = m_rd + 1;
        step(w, rd_new, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
